// File: rtl/phys_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : phys_mem_responder_pkg
//  Purpose  : Shared bus widths, FSM state encoding and helpers for the
//             physical-address memory responder.
//  Revision : 1.0 - initial release
// ============================================================================
package phys_mem_responder_pkg;

  localparam int ADDR_BUS = 32;
  localparam int DATA_BUS = 32;
  localparam int SEL_W    = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  // True when any byte-address bit above the RAM window is set.
  function automatic logic addr_out_of_range(input logic [ADDR_BUS-1:0] addr,
                                             input int unsigned aw);
    logic r;
    r = 1'b0;
    for (int unsigned b = 0; b < ADDR_BUS; b++) begin
      if (b >= aw + 2) r = r | addr[b];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/phys_mem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module   : phys_mem_responder_if
//  Purpose  : Request/response valid-ready bus between the translation stage
//             (master) and the memory responder (slave).
//  Revision : 1.0 - initial release
// ============================================================================
interface phys_mem_responder_if;
  import phys_mem_responder_pkg::*;

  logic                req_valid;
  logic                req_ready;
  logic                req_write;
  logic [ADDR_BUS-1:0] req_addr;
  logic [DATA_BUS-1:0] req_wdata;
  logic [SEL_W-1:0]    req_sel;
  logic                resp_valid;
  logic                resp_ready;
  logic [DATA_BUS-1:0] resp_rdata;
  logic                resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_sel, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_sel, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface
`default_nettype wire

// File: rtl/phys_mem_responder_byte_ram.sv
`default_nettype none
// ============================================================================
//  Module   : phys_mem_responder_byte_ram
//  Purpose  : Single-port synchronous word RAM with per-byte write enables
//             and a read-first registered output that holds while i_en=0.
//  Revision : 1.0 - initial release
// ============================================================================
module phys_mem_responder_byte_ram
  import phys_mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  wire logic                  clk,
  input  wire logic                  i_en,
  input  wire logic [SEL_W-1:0]      i_we,
  input  wire logic [ADDR_WIDTH-1:0] i_addr,
  input  wire logic [DATA_BUS-1:0]   i_wdata,
  output logic      [DATA_BUS-1:0]   o_q
);

  localparam int c_DEPTH = 1 << ADDR_WIDTH;

  // One byte-wide array per lane keeps each lane an independent RAM.
  for (genvar i = 0; i < SEL_W; i++) begin : g_lane
    logic [7:0] r_mem [c_DEPTH];
    logic [7:0] r_q;

    // Read-first access: output captures the old contents, then lane writes.
    always_ff @(posedge clk) begin
      if (i_en) begin
        r_q <= r_mem[i_addr];
        if (i_we[i]) r_mem[i_addr] <= i_wdata[8*i +: 8];
      end
    end

    assign o_q[8*i +: 8] = r_q;
  end

endmodule
`default_nettype wire

// File: rtl/phys_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : phys_mem_responder
//  Purpose  : Physical-bus memory target: accepts one request, waits LATENCY
//             cycles, accesses the byte RAM, then returns data/error.
//  Revision : 1.0 - initial release
// ============================================================================
module phys_mem_responder
  import phys_mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 2
) (
  input  wire logic           clk,
  input  wire logic           rst,
  phys_mem_responder_if.slave bus
);

  localparam logic [3:0] c_LAT_M1 = 4'((LATENCY == 0) ? 0 : LATENCY - 1);

  state_e              r_state;
  logic [3:0]          r_cnt;
  logic                r_write;
  logic [ADDR_BUS-1:0] r_addr;
  logic [DATA_BUS-1:0] r_wdata;
  logic [SEL_W-1:0]    r_sel;
  logic                r_resp_err;
  logic                r_rd_ok;

  logic                  w_err;
  logic                  w_ram_en;
  logic [SEL_W-1:0]      w_ram_we;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic [DATA_BUS-1:0]   w_ram_q;
  logic                  w_unused_ok;

  assign w_err    = addr_out_of_range(r_addr, ADDR_WIDTH);
  assign w_idx    = r_addr[ADDR_WIDTH+1:2];
  // Reset in the ACCESS cycle wins: the array is left untouched.
  assign w_ram_en = (r_state == ST_ACCESS) && !rst;
  assign w_ram_we = (w_ram_en && r_write && !w_err) ? r_sel : '0;

  // Byte offset bits are deliberately ignored; alignment is upstream's job.
  assign w_unused_ok = &{1'b0, r_addr[1:0]};

  assign bus.req_ready  = (r_state == ST_IDLE);
  assign bus.resp_valid = (r_state == ST_RESP);
  assign bus.resp_err   = r_resp_err;
  // RAM output register is only refreshed in ACCESS, so it is stable in RESP.
  assign bus.resp_rdata = r_rd_ok ? w_ram_q : '0;

  phys_mem_responder_byte_ram #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .i_en    (w_ram_en),
    .i_we    (w_ram_we),
    .i_addr  (w_idx),
    .i_wdata (r_wdata),
    .o_q     (w_ram_q)
  );

  // Transaction FSM: accept, wait-state count, single access cycle, response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_write    <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_sel      <= '0;
      r_resp_err <= 1'b0;
      r_rd_ok    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            r_write <= bus.req_write;
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
            r_sel   <= bus.req_sel;
            if (LATENCY == 0) begin
              r_state <= ST_ACCESS;
            end else begin
              r_cnt   <= c_LAT_M1;
              r_state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (r_cnt == 4'd0) r_state <= ST_ACCESS;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        ST_ACCESS: begin
          r_resp_err <= w_err;
          r_rd_ok    <= !r_write && !w_err;
          r_state    <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.resp_ready) begin
            r_resp_err <= 1'b0;
            r_rd_ok    <= 1'b0;
            r_state    <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_phys_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_phys_mem_responder
//  Purpose  : Directed self-checking bench; one DUT with LATENCY=2 and one
//             with LATENCY=0 sharing clock and reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_phys_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  phys_mem_responder_if bus2 ();
  phys_mem_responder_if bus0 ();

  phys_mem_responder #(.ADDR_WIDTH(12), .LATENCY(2)) dut2 (
    .clk (clk), .rst (rst), .bus (bus2.slave)
  );
  phys_mem_responder #(.ADDR_WIDTH(12), .LATENCY(0)) dut0 (
    .clk (clk), .rst (rst), .bus (bus0.slave)
  );

  task automatic drive_req(input bit b0, input logic v, input logic wr,
                           input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (b0) begin
      bus0.req_valid = v; bus0.req_write = wr; bus0.req_addr = a;
      bus0.req_wdata = d; bus0.req_sel = s;
    end else begin
      bus2.req_valid = v; bus2.req_write = wr; bus2.req_addr = a;
      bus2.req_wdata = d; bus2.req_sel = s;
    end
  endtask

  function automatic logic get_ready(input bit b0);
    return b0 ? bus0.req_ready : bus2.req_ready;
  endfunction

  function automatic logic get_rv(input bit b0);
    return b0 ? bus0.resp_valid : bus2.resp_valid;
  endfunction

  // Runs one transaction starting at a negedge; returns at the negedge after
  // the response handshake. lat counts cycles from acceptance to resp_valid.
  task automatic txn(input bit b0, input logic wr, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] s,
                     output logic [31:0] rd, output logic e, output int lat, output int acc);
    acc = 0; lat = 999; rd = 'x; e = 1'bx;
    if (b0) bus0.resp_ready = 1'b1; else bus2.resp_ready = 1'b1;
    drive_req(b0, 1'b1, wr, a, d, s);
    while (!get_ready(b0) && acc < 40) begin @(negedge clk); acc++; end
    if (acc >= 40) begin drive_req(b0, 1'b0, 1'b0, '0, '0, '0); return; end
    @(negedge clk);
    drive_req(b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'hF);
    lat = 1;
    while (!get_rv(b0) && lat < 40) begin @(negedge clk); lat++; end
    if (lat >= 40) begin lat = 999; return; end
    rd = b0 ? bus0.resp_rdata : bus2.resp_rdata;
    e  = b0 ? bus0.resp_err   : bus2.resp_err;
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive_req(1'b0, 1'b0, 1'b0, '0, '0, '0);
    drive_req(1'b1, 1'b0, 1'b0, '0, '0, '0);
    bus2.resp_ready = 1'b1; bus0.resp_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    checks++; if (bus2.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", bus2.req_ready); end
    checks++; if (bus2.resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got=%b exp=0", bus2.resp_valid); end
    checks++; if (bus2.resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", bus2.resp_rdata); end
    checks++; if (bus2.resp_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", bus2.resp_err); end
    checks++; if (bus0.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready0 got=%b exp=1", bus0.req_ready); end
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic e; int lat, acc;
    txn(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, rd, e, lat, acc);
    checks++; if (rd !== 32'h0 || e !== 1'b0) begin errors++; $display("FAIL wr_resp got=%h/%b exp=00000000/0", rd, e); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL wr_latency got=%0d exp=4", lat); end
    txn(1'b0, 1'b0, 32'h0000_0010, 32'h0, 4'hF, rd, e, lat, acc);
    checks++; if (rd !== 32'hDEAD_BEEF || e !== 1'b0) begin errors++; $display("FAIL rd_full got=%h/%b exp=deadbeef/0", rd, e); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL rd_latency got=%0d exp=4", lat); end
  endtask

  task automatic test_partial();
    logic [31:0] rd; logic e; int lat, acc;
    txn(1'b0, 1'b1, 32'h0000_0010, 32'h0000_5500, 4'b0010, rd, e, lat, acc);
    txn(1'b0, 1'b0, 32'h0000_0010, 32'h0, 4'b0000, rd, e, lat, acc);
    checks++; if (rd !== 32'hDEAD_55EF) begin errors++; $display("FAIL partial_lane1 got=%h exp=dead55ef", rd); end
    txn(1'b0, 1'b1, 32'h0000_0010, 32'h1111_1111, 4'b0000, rd, e, lat, acc);
    txn(1'b0, 1'b0, 32'h0000_0010, 32'h0, 4'b0001, rd, e, lat, acc);
    checks++; if (rd !== 32'hDEAD_55EF) begin errors++; $display("FAIL sel0_noop got=%h exp=dead55ef", rd); end
    txn(1'b0, 1'b1, 32'h0000_0010, 32'hAA00_00BB, 4'b1001, rd, e, lat, acc);
    txn(1'b0, 1'b0, 32'h0000_0013, 32'h0, 4'b0000, rd, e, lat, acc);
    checks++; if (rd !== 32'hAAAD_55BB) begin errors++; $display("FAIL lanes_0_3_unaligned got=%h exp=aaad55bb", rd); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd; logic e; int lat, acc;
    txn(1'b0, 1'b0, 32'h0000_4000, 32'h0, 4'hF, rd, e, lat, acc);
    checks++; if (rd !== 32'h0 || e !== 1'b1) begin errors++; $display("FAIL oor_read got=%h/%b exp=00000000/1", rd, e); end
    txn(1'b0, 1'b1, 32'h0000_4010, 32'hFFFF_FFFF, 4'hF, rd, e, lat, acc);
    checks++; if (rd !== 32'h0 || e !== 1'b1) begin errors++; $display("FAIL oor_write got=%h/%b exp=00000000/1", rd, e); end
    txn(1'b0, 1'b0, 32'h8000_0010, 32'h0, 4'hF, rd, e, lat, acc);
    checks++; if (rd !== 32'h0 || e !== 1'b1) begin errors++; $display("FAIL oor_msb got=%h/%b exp=00000000/1", rd, e); end
    txn(1'b0, 1'b0, 32'h0000_0010, 32'h0, 4'hF, rd, e, lat, acc);
    checks++; if (rd !== 32'hAAAD_55BB || e !== 1'b0) begin errors++; $display("FAIL oor_no_alias got=%h/%b exp=aaad55bb/0", rd, e); end
    txn(1'b0, 1'b1, 32'h0000_3FFC, 32'h0102_0304, 4'hF, rd, e, lat, acc);
    txn(1'b0, 1'b0, 32'h0000_3FFC, 32'h0, 4'hF, rd, e, lat, acc);
    checks++; if (rd !== 32'h0102_0304 || e !== 1'b0) begin errors++; $display("FAIL last_word got=%h/%b exp=01020304/0", rd, e); end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; logic e; int lat, acc, n;
    bus2.resp_ready = 1'b0;
    drive_req(1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'hF);
    @(negedge clk);
    // Stray request while busy must be ignored.
    drive_req(1'b0, 1'b1, 1'b1, 32'h0000_0010, 32'h0, 4'hF);
    n = 0;
    while (!bus2.resp_valid && n < 20) begin @(negedge clk); n++; end
    checks++; if (n >= 20) begin errors++; $display("FAIL bp_resp_timeout got=%0d exp<20", n); end
    for (int k = 0; k < 6; k++) begin
      checks++; if (bus2.resp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got=%b exp=1", k, bus2.resp_valid); end
      checks++; if (bus2.resp_rdata !== 32'hAAAD_55BB) begin errors++; $display("FAIL bp_rdata[%0d] got=%h exp=aaad55bb", k, bus2.resp_rdata); end
      checks++; if (bus2.resp_err !== 1'b0) begin errors++; $display("FAIL bp_err[%0d] got=%b exp=0", k, bus2.resp_err); end
      checks++; if (bus2.req_ready !== 1'b0) begin errors++; $display("FAIL bp_req_ready[%0d] got=%b exp=0", k, bus2.req_ready); end
      @(negedge clk);
    end
    drive_req(1'b0, 1'b0, 1'b0, '0, '0, '0);
    bus2.resp_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus2.req_ready !== 1'b1 || bus2.resp_valid !== 1'b0) begin errors++; $display("FAIL bp_release got=%b/%b exp=1/0", bus2.req_ready, bus2.resp_valid); end
    txn(1'b0, 1'b0, 32'h0000_0010, 32'h0, 4'hF, rd, e, lat, acc);
    checks++; if (rd !== 32'hAAAD_55BB) begin errors++; $display("FAIL bp_stray_ignored got=%h exp=aaad55bb", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic e; int lat, acc;
    txn(1'b0, 1'b1, 32'h0000_0030, 32'h1122_3344, 4'hF, rd, e, lat, acc);
    txn(1'b0, 1'b0, 32'h0000_0030, 32'h0, 4'hF, rd, e, lat, acc);
    checks++; if (acc !== 0) begin errors++; $display("FAIL b2b_accept_wait got=%0d exp=0", acc); end
    checks++; if (rd !== 32'h1122_3344) begin errors++; $display("FAIL b2b_rdata got=%h exp=11223344", rd); end
  endtask

  task automatic test_reset_midop();
    logic [31:0] rd; logic e; int lat, acc, seen;
    // LATENCY=2: reset lands in WAIT.
    txn(1'b0, 1'b1, 32'h0000_0020, 32'hA5A5_A5A5, 4'hF, rd, e, lat, acc);
    drive_req(1'b0, 1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678, 4'hF);
    @(negedge clk);
    drive_req(1'b0, 1'b0, 1'b0, '0, '0, '0);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    seen = 0;
    repeat (8) begin @(negedge clk); if (bus2.resp_valid) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rst_wait_no_resp got=%0d exp=0", seen); end
    txn(1'b0, 1'b0, 32'h0000_0020, 32'h0, 4'hF, rd, e, lat, acc);
    checks++; if (rd !== 32'hA5A5_A5A5) begin errors++; $display("FAIL rst_wait_mem got=%h exp=a5a5a5a5", rd); end
    // LATENCY=0: reset lands exactly in ACCESS.
    txn(1'b1, 1'b1, 32'h0000_0020, 32'h0BAD_F00D, 4'hF, rd, e, lat, acc);
    checks++; if (lat !== 2) begin errors++; $display("FAIL lat0_latency got=%0d exp=2", lat); end
    drive_req(1'b1, 1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678, 4'hF);
    @(negedge clk);
    drive_req(1'b1, 1'b0, 1'b0, '0, '0, '0);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    seen = 0;
    repeat (6) begin @(negedge clk); if (bus0.resp_valid) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rst_access_no_resp got=%0d exp=0", seen); end
    txn(1'b1, 1'b0, 32'h0000_0020, 32'h0, 4'hF, rd, e, lat, acc);
    checks++; if (rd !== 32'h0BAD_F00D) begin errors++; $display("FAIL rst_access_mem got=%h exp=0badf00d", rd); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_partial();
    test_out_of_range();
    test_backpressure();
    test_back_to_back();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
